pwm_multi: RTL and testbench

- Multi-channel PWM generator. One shared period counter with a prescaler drives CHANNELS comparators.
- Each channel has a double-buffered duty register, so duty updates are glitch-free at period boundaries.
- Supports edge-aligned and center-aligned modes, per-channel output polarity and a period-end tick.
- Sits beside the LED/GPIO logic on the board top level and is written by a simple register-write strobe.

---
 rtl/pwm_pkg.sv | 24 ++
 rtl/pwm_timebase.sv | 87 ++++++++
 rtl/pwm_multi.sv | 79 +++++++
 tb/tb_pwm_multi.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// Shared definitions for the multi-channel PWM block: mode encodings, default sizes
// and the channel-select width helper.
package pwm_pkg;

    localparam int unsigned PWM_WIDTH_DEF      = 8;
    localparam int unsigned PWM_CHANNELS_DEF   = 4;
    localparam int unsigned PWM_PRESCALE_W_DEF = 8;

    typedef enum logic {
        PWM_EDGE   = 1'b0,
        PWM_CENTER = 1'b1
    } pwm_mode_e;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } pwm_dir_e;

    // A single channel still needs a one-bit select.
    function automatic int unsigned ch_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pwm_timebase.sv
// Shared PWM timebase: prescaler, edge/center counter, shadowed top and the
// period-boundary pulse that also gates duty-buffer loads.
module pwm_timebase
    import pwm_pkg::*;
#(
    parameter int unsigned WIDTH      = PWM_WIDTH_DEF,
    parameter int unsigned PRESCALE_W = PWM_PRESCALE_W_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic [WIDTH-1:0]      top,
    input  logic [PRESCALE_W-1:0] prescale,
    input  logic                  center_mode,
    output logic [WIDTH-1:0]      counter,
    output logic                  load_c,
    output logic                  period_tick
);

    logic [PRESCALE_W-1:0] presc_q;
    logic [WIDTH-1:0]      top_q;
    logic [WIDTH-1:0]      cnt_d;
    pwm_dir_e              dir_q;
    pwm_dir_e              dir_d;
    pwm_mode_e             mode_c;
    logic                  tick_c;
    logic                  up_move_c;
    logic                  boundary_c;

    // Next counter value, direction and boundary detection for one tick.
    always_comb begin
        mode_c     = pwm_mode_e'(center_mode);
        tick_c     = en && (presc_q == prescale);
        cnt_d      = counter;
        dir_d      = dir_q;
        up_move_c  = 1'b0;
        boundary_c = 1'b0;
        if (tick_c) begin
            if (mode_c == PWM_EDGE) begin
                dir_d = DIR_UP;
                if (counter >= top_q) begin
                    cnt_d      = '0;
                    boundary_c = 1'b1;
                end else begin
                    cnt_d = counter + WIDTH'(1);
                end
            end else if (top_q == '0) begin
                cnt_d      = '0;
                dir_d      = DIR_UP;
                boundary_c = 1'b1;
            end else begin
                // Turn around at either end without repeating the end value.
                up_move_c  = (counter == '0) || ((dir_q == DIR_UP) && (counter < top_q));
                cnt_d      = up_move_c ? counter + WIDTH'(1) : counter - WIDTH'(1);
                dir_d      = ((cnt_d == '0) || (up_move_c && (cnt_d < top_q))) ? DIR_UP : DIR_DOWN;
                boundary_c = (cnt_d == '0);
            end
        end
    end

    assign load_c = !en || boundary_c;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q     <= '0;
            counter     <= '0;
            dir_q       <= DIR_UP;
            top_q       <= '0;
            period_tick <= 1'b0;
        end else if (!en) begin
            presc_q     <= '0;
            counter     <= '0;
            dir_q       <= DIR_UP;
            top_q       <= top;
            period_tick <= 1'b0;
        end else begin
            presc_q     <= tick_c ? '0 : presc_q + PRESCALE_W'(1);
            counter     <= cnt_d;
            dir_q       <= dir_d;
            period_tick <= boundary_c;
            if (boundary_c) begin
                top_q <= top;
            end
        end
    end

endmodule

// File: rtl/pwm_multi.sv
// Multi-channel PWM: one shared timebase feeding per-channel double-buffered duty
// comparators with selectable output polarity.
module pwm_multi
    import pwm_pkg::*;
#(
    parameter int unsigned  WIDTH      = PWM_WIDTH_DEF,
    parameter int unsigned  CHANNELS   = PWM_CHANNELS_DEF,
    parameter int unsigned  PRESCALE_W = PWM_PRESCALE_W_DEF,
    localparam int unsigned CH_W       = ch_width(CHANNELS)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  wr_en,
    input  logic [CH_W-1:0]       wr_ch,
    input  logic [WIDTH-1:0]      wr_duty,
    input  logic [WIDTH-1:0]      top,
    input  logic [PRESCALE_W-1:0] prescale,
    input  logic                  center_mode,
    input  logic [CHANNELS-1:0]   polarity,
    output logic [CHANNELS-1:0]   pwm_out,
    output logic                  period_tick
);

    logic [WIDTH-1:0]    counter;
    logic                load_c;
    logic [CHANNELS-1:0] raw_c;

    pwm_timebase #(
        .WIDTH      (WIDTH),
        .PRESCALE_W (PRESCALE_W)
    ) u_timebase (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .top         (top),
        .prescale    (prescale),
        .center_mode (center_mode),
        .counter     (counter),
        .load_c      (load_c),
        .period_tick (period_tick)
    );

    // Per-channel pending/active duty pair; active only changes on load.
    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        logic [WIDTH-1:0] pend_q;
        logic [WIDTH-1:0] act_q;
        logic             wr_hit_c;

        assign wr_hit_c = wr_en && (wr_ch == CH_W'(g));

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                pend_q <= '0;
                act_q  <= '0;
            end else begin
                if (load_c) begin
                    act_q <= pend_q;
                end
                if (wr_hit_c) begin
                    pend_q <= wr_duty;
                end
            end
        end

        assign raw_c[g] = (counter < act_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm_out <= '0;
        end else if (!en) begin
            pwm_out <= polarity;
        end else begin
            pwm_out <= raw_c ^ polarity;
        end
    end

endmodule

// File: tb/tb_pwm_multi.sv
// Scoreboard bench for pwm_multi: a period-position model predicts every output cycle,
// a monitor compares on the falling edge.
module tb_pwm_multi;

    localparam int unsigned W   = 8;
    localparam int unsigned CH  = 4;
    localparam int unsigned PW  = 8;
    localparam int unsigned CHW = 2;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           en = 1'b0;
    logic           wr_en = 1'b0;
    logic [CHW-1:0] wr_ch = '0;
    logic [W-1:0]   wr_duty = '0;
    logic [W-1:0]   top = '0;
    logic [PW-1:0]  prescale = '0;
    logic           center_mode = 1'b0;
    logic [CH-1:0]  polarity = '0;
    logic [CH-1:0]  pwm_out;
    logic           period_tick;

    pwm_multi #(.WIDTH(W), .CHANNELS(CH), .PRESCALE_W(PW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .wr_en       (wr_en),
        .wr_ch       (wr_ch),
        .wr_duty     (wr_duty),
        .top         (top),
        .prescale    (prescale),
        .center_mode (center_mode),
        .polarity    (polarity),
        .pwm_out     (pwm_out),
        .period_tick (period_tick)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [CH-1:0] pwm;
        logic          tick;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_fail = 0;

    // Model: position within the period, clocks since last tick, duty/top copies.
    int m_pre, m_pos, m_top;
    int m_act[CH];
    int m_pend[CH];

    function automatic int period_len();
        if (center_mode) return (m_top == 0) ? 1 : 2 * m_top;
        return m_top + 1;
    endfunction

    function automatic int cur_val();
        if (center_mode && (m_pos > m_top)) return 2 * m_top - m_pos;
        return m_pos;
    endfunction

    function automatic bit boundary_next();
        return en && (m_pre == int'(prescale)) && (m_pos + 1 >= period_len());
    endfunction

    task automatic model_reset();
        m_pre = 0;
        m_pos = 0;
        m_top = 0;
        for (int i = 0; i < CH; i++) begin
            m_act[i]  = 0;
            m_pend[i] = 0;
        end
    endtask

    // Predict outputs after the coming rising edge from the current inputs.
    task automatic commit();
        exp_t e;
        e = '0;
        if (!rst_n) begin
            model_reset();
        end else if (!en) begin
            e.pwm = polarity;
            for (int i = 0; i < CH; i++) m_act[i] = m_pend[i];
            m_top = int'(top);
            m_pos = 0;
            m_pre = 0;
        end else begin
            for (int i = 0; i < CH; i++) e.pwm[i] = (cur_val() < m_act[i]) ^ polarity[i];
            if (m_pre == int'(prescale)) begin
                m_pre = 0;
                m_pos++;
                if (m_pos >= period_len()) begin
                    m_pos  = 0;
                    e.tick = 1'b1;
                    for (int i = 0; i < CH; i++) m_act[i] = m_pend[i];
                    m_top = int'(top);
                end
            end else begin
                m_pre++;
            end
        end
        if (rst_n && wr_en) m_pend[wr_ch] = int'(wr_duty);
        sb_q.push_back(e);
    endtask

    task automatic sync();
        @(negedge clk);
        #1;
        wr_en = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            sync();
            commit();
        end
    endtask

    task automatic write(input int ch, input int duty);
        sync();
        wr_en   = 1'b1;
        wr_ch   = CHW'(ch);
        wr_duty = W'(duty);
        commit();
    endtask

    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            mon_e = sb_q.pop_front();
            n_checks++;
            if ({pwm_out, period_tick} !== mon_e) begin
                n_fail++;
                $display("FAIL sb t=%0t pwm_out=%b period_tick=%b expected pwm_out=%b period_tick=%b",
                         $time, pwm_out, period_tick, mon_e.pwm, mon_e.tick);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog t=%0t bench did not finish", $time);
        $fatal(1);
    end

    initial begin
        bit found;
        model_reset();

        // Reset, then idle with inactive levels
        sync(); rst_n = 1'b0; polarity = 4'b0101; commit();
        idle(2);
        sync(); rst_n = 1'b1; commit();
        idle(4);

        // Edge mode, top=9, prescale=0, extremes on ch1..ch3
        sync(); polarity = '0; top = 8'd9; prescale = '0; center_mode = 1'b0; commit();
        write(0, 3);
        write(1, 0);
        write(2, 10);
        write(3, 255);
        sync(); en = 1'b1; commit();
        idle(34);

        // Mid-period update, then a write landing exactly on a boundary
        write(0, 7);
        idle(25);
        found = 1'b0;
        for (int k = 0; k < 100; k++) begin
            if (boundary_next()) begin
                found = 1'b1;
                break;
            end
            idle(1);
        end
        n_checks++;
        if (!found) begin
            n_fail++;
            $display("FAIL boundary_wait no boundary seen within 100 cycles");
        end
        write(0, 5);
        idle(25);

        // Center mode, top=4, prescale=1, duty=2
        sync(); en = 1'b0; center_mode = 1'b1; top = 8'd4; prescale = 8'd1; commit();
        write(0, 2);
        sync(); en = 1'b1; commit();
        idle(40);

        // Randomised run
        for (int c = 0; c < 400; c++) begin
            sync();
            if ($urandom_range(49, 0) == 0) en = ~en;
            if (!en) begin
                center_mode = 1'($urandom_range(1, 0));
                prescale    = PW'($urandom_range(3, 0));
            end
            if ($urandom_range(39, 0) == 0) top = W'($urandom_range(12, 0));
            if ($urandom_range(29, 0) == 0) polarity = CH'($urandom);
            if ($urandom_range(3, 0) == 0) begin
                wr_en   = 1'b1;
                wr_ch   = CHW'($urandom_range(CH - 1, 0));
                wr_duty = W'($urandom_range(15, 0));
            end
            commit();
        end

        // Async reset between edges while some outputs are high
        sync(); en = 1'b0; center_mode = 1'b0; top = 8'd9; prescale = '0; polarity = 4'b1010; commit();
        write(3, 255);
        sync(); en = 1'b1; commit();
        idle(5);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ((pwm_out !== '0) || (period_tick !== 1'b0)) begin
            n_fail++;
            $display("FAIL async_rst pwm_out=%b period_tick=%b expected pwm_out=0000 period_tick=0",
                     pwm_out, period_tick);
        end
        sb_q.delete();
        model_reset();
        sync(); polarity = '0; commit();
        sync(); rst_n = 1'b1; commit();
        idle(20);
        write(2, 4);
        idle(30);

        @(negedge clk);
        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
